// File: rtl/lane_pkg.sv
// Shared lane-map types: lane codes, ring depth, LFSR constants and FSM states.
// Also used by the car spawner for LFSR tap constants.
package lane_pkg;
  typedef enum logic [1:0] {
    SIDEWALK  = 2'b00,
    ROAD_L    = 2'b01,
    ROAD_R    = 2'b10,
    ROAD_FAST = 2'b11
  } lane_t;

  localparam int LANE_DEPTH = 16;
  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 as a bit mask
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with feedback into bit 0.
// Async active-high reset loads SEED.
module lfsr16
  import lane_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/lane_map.sv
// Ring buffer of lane types regenerated as the scroll advances.
// Option: LANE_MAP_SAFE_START_EN forces FILL slots 0..2 to SIDEWALK.
module lane_map
  import lane_pkg::*;
#(
  parameter int          LANE_SHIFT = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MAX_ROADS  = 3
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        game_rst,
  input  logic [10:0] pos,
  input  logic [9:0]  vpos,
  output logic [1:0]  lane_type,
  output logic        busy
);

  localparam int IW = 11 - LANE_SHIFT;
  localparam int RW = $clog2(MAX_ROADS + 1);

  state_t        state, state_nxt;
  lane_t         lanes [LANE_DEPTH];
  logic [3:0]    fill_cnt, fill_nxt;
  logic [IW-1:0] last_idx, last_nxt, cur_idx;
  logic [RW-1:0] road_run, run_nxt;
  logic [15:0]   lfsr;
  logic [10:0]   row;
  logic [3:0]    rd_slot, wr_slot;
  logic          wr_en;
  lane_t         cand;
  logic          unused_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (sys_rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  assign row     = pos + {1'b0, vpos};
  assign rd_slot = row[LANE_SHIFT+3:LANE_SHIFT];
  assign cur_idx = pos[10:LANE_SHIFT];
  assign busy    = (state == FILL);

  assign unused_bits = ^{lfsr[15:2], row[LANE_SHIFT-1:0],
                         row[10:LANE_SHIFT+4]};

  always_comb begin
    cand = lane_t'(lfsr[1:0]);
    if (road_run == RW'(MAX_ROADS)) cand = SIDEWALK;
`ifdef LANE_MAP_SAFE_START_EN
    if (state == FILL && fill_cnt < 4'd3) cand = SIDEWALK;
`else
`endif
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    last_nxt  = last_idx;
    run_nxt   = road_run;
    wr_en     = 1'b0;
    wr_slot   = fill_cnt;
    if (game_rst) begin
      state_nxt = FILL;
      fill_nxt  = 4'd0;
      run_nxt   = '0;
    end else begin
      unique case (state)
        FILL: begin
          wr_en    = 1'b1;
          fill_nxt = fill_cnt + 4'd1;
          run_nxt  = (cand == SIDEWALK) ? '0 : road_run + RW'(1);
          if (fill_cnt == 4'd15) begin
            state_nxt = RUN;
            last_nxt  = cur_idx;
            run_nxt   = '0;
          end
        end
        RUN: begin
          if (cur_idx != last_idx) begin
            wr_en    = 1'b1;
            wr_slot  = last_idx[3:0];
            last_nxt = last_idx + IW'(1);
            run_nxt  = (cand == SIDEWALK) ? '0 : road_run + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= FILL;
      fill_cnt  <= 4'd0;
      last_idx  <= '0;
      road_run  <= '0;
      lane_type <= SIDEWALK;
      for (int i = 0; i < LANE_DEPTH; i++) lanes[i] <= SIDEWALK;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      last_idx <= last_nxt;
      road_run <= run_nxt;
      if (wr_en) lanes[wr_slot] <= cand;
      // old slot value is read even when written this edge
      lane_type <= (state_nxt == FILL) ? SIDEWALK : lanes[rd_slot];
    end
  end

endmodule

// File: doc/lane_map.md
# lane_map

Downstream consumer of the scroll position in the crossy-road VGA datapath. Holds a 16-entry ring buffer of lane types (sidewalk or one of three road kinds), regenerates lanes pseudo-randomly as the scroll position advances, and answers per-scanline lookups for the renderer. Sits between `scroll` (`pos`) and the pixel/car renderers (`lane_type`).

## Interface
Parameters:
- `LANE_SHIFT`, 5: lane height = 2^LANE_SHIFT pixels; legal 5..6. 16 slots cover ≥ 480/2^LANE_SHIFT + 1 lanes.
- `LFSR_SEED`, 16'hACE1: LFSR value loaded on `sys_rst`; must be nonzero.
- `MAX_ROADS`, 3: maximum consecutive road lanes; the next generated lane after a full run is forced to SIDEWALK.

Ports:
- `clk`  in  1  system clock (25 MHz pixel clock)
- `sys_rst`  in  1  asynchronous, active-high reset
- `game_rst`  in  1  synchronous, active-high level; rebuilds the map
- `pos`  in  11  world scroll position from `scroll`, in pixels; wraps modulo 2048
- `vpos`  in  10  current VGA scanline, 0..479
- `lane_type`  out  2  registered lane type for world row `pos+vpos`
- `busy`  out  1  map being rebuilt; `lane_type` is SIDEWALK while high

## Operation
- Lane codes: 00 SIDEWALK, 01 ROAD_L, 10 ROAD_R, 11 ROAD_FAST.
- Lookup: `row = (pos + vpos)` mod 2048 (11-bit); `lane = row >> LANE_SHIFT`; `slot = lane[3:0]`; `lane_type <= buf[slot]` each cycle.
- Generator: 16-bit Fibonacci LFSR, taps 16,14,13,11, steps every cycle, including FILL and game_rst. It is not reloaded by `game_rst`, so each game gets a different map. Candidate type is `lfsr[1:0]`. If `road_run == MAX_ROADS`, SIDEWALK is forced. `road_run` clears on a SIDEWALK write and increments on a road write.
- States:
  - FILL: writes slots 0..15 in order, one per cycle, with `busy=1`. After the 16th write: `last_idx <= pos >> LANE_SHIFT`, `road_run <= 0`, go to RUN.
  - RUN: if `pos >> LANE_SHIFT != last_idx`, regenerate `buf[last_idx[3:0]]` and increment `last_idx` (modulo 2^(11-LANE_SHIFT)). At most one lane per cycle; larger jumps catch up over successive cycles, including across the wrap.
- `game_rst` high in any state: go to FILL, fill counter = 0, no buffer write that cycle, `road_run <= 0`. This has priority over regeneration. `game_rst` held high keeps the block at slot 0.
- In FILL, changes to `pos` are ignored.

## Timing
- `sys_rst` values:
  - buffer all SIDEWALK, `lane_type=00`, `busy=1`
  - state FILL, fill counter 0, `last_idx=0`, `road_run=0`, LFSR=`LFSR_SEED`
- FILL write k (k=0..15) happens on the (k+1)th rising edge with `game_rst` low. `busy` falls on the edge of the 16th write, i.e. 16 cycles after release.
- Lookup latency: 1 cycle from `vpos`/`pos` to `lane_type`. `lane_type` is forced 00 while `busy`.
- Regeneration write and lookup of the same slot in the same cycle: the lookup returns the old value (read-before-write).

## Configuration
- `LANE_MAP_SAFE_START_EN` defined: FILL forces slots 0..2 to SIDEWALK (LFSR still steps) and `road_run` starts counting at slot 3.
- Undefined: all 16 FILL slots come from the generator under the run rule.

## Structure
- Package `lane_pkg`:
  - `lane_t` enum (SIDEWALK, ROAD_L, ROAD_R, ROAD_FAST)
  - `LANE_DEPTH=16`, LFSR width and tap constants
  - FSM state enum {FILL, RUN}
- One sub-module, `lfsr16`: seed parameter, enable tied high, async reset. Shared with the car spawner.

## Test plan
- Release `sys_rst` with `game_rst` low -> `busy` high for exactly 16 cycles. With `LANE_MAP_SAFE_START_EN`, `pos=0`, `vpos=0..95` gives `lane_type=00` after `busy` falls.
- RUN, `pos` 31->32 -> exactly one write to slot 0 on the next edge; `last_idx` becomes 1; no other slot changes.
- `pos` jumps 0->128 in one cycle -> slots 0,1,2,3 rewritten on four consecutive cycles, then idle.
- Wrap, `pos` 2047->0 (lane 63->0) -> slot 15 regenerated once; `last_idx` becomes 0.
- Step `vpos` 0->32 with `pos=0` -> `lane_type` shows `buf[1]` one cycle later. `game_rst` pulsed mid-RUN -> `busy` high 16 cycles and `lane_type=00` during FILL.
- Free-run 10 000 lane advances -> never more than 3 consecutive road lanes; all four codes occur.
